// File: rtl/bus_rr_arbiter.sv
// Round-robin bus arbiter with multi-beat ownership, a per-tenure beat limit
// and a one-cycle read-response strobe per host.
module bus_rr_arbiter #(
    parameter int Hosts    = 4,
    parameter int MaxHold  = 8,
    parameter int HOST_NUM = (Hosts > 1) ? $clog2(Hosts) : 1,
    parameter int CNT_W    = $clog2(MaxHold + 1)
) (
    input  logic                clk_in,
    input  logic                reset_in,
    input  logic [Hosts-1:0]    req_in,
    input  logic [Hosts-1:0]    we_in,
    input  logic [Hosts-1:0]    lock_in,
    output logic [Hosts-1:0]    gnt_out,
    output logic [HOST_NUM-1:0] owner_out,
    output logic                busy_out,
    output logic [Hosts-1:0]    resp_valid_out,
    output logic [CNT_W-1:0]    beat_cnt_out
);

    typedef enum logic {
        S_IDLE,
        S_OWNED
    } state_t;

    localparam logic [HOST_NUM-1:0] OWNER_RST = HOST_NUM'(Hosts - 1);
    localparam logic [CNT_W-1:0]    CNT_MAX   = CNT_W'(MaxHold);
    localparam logic [CNT_W:0]      HOLD_LIM  = (CNT_W + 1)'(MaxHold);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [HOST_NUM-1:0] r_owner;
    logic [HOST_NUM-1:0] w_owner_nxt;
    logic [CNT_W-1:0]    r_beat_cnt;
    logic [CNT_W-1:0]    w_beat_cnt_nxt;
    logic [Hosts-1:0]    r_resp_valid;

    logic [Hosts-1:0]    w_owner_oh;
    logic [Hosts-1:0]    w_others;
    logic [Hosts-1:0]    w_pick_req;
    logic [Hosts-1:0]    w_gnt;
    logic [HOST_NUM-1:0] w_pick;
    logic                w_pick_hit;
    logic [CNT_W:0]      w_cnt_inc;
    logic                w_owner_req;
    logic                w_owner_lock;
    logic                w_any_other;
    logic                w_hold_limit;
    logic                w_cnt_sat;
    int                  w_idx;

    always_comb begin
        w_owner_oh = '0;
        for (int h = 0; h < Hosts; h++) begin
            w_owner_oh[h] = (r_owner == HOST_NUM'(h));
        end
    end

    assign w_owner_req  = |(req_in & w_owner_oh);
    assign w_owner_lock = |(lock_in & w_owner_oh);
    assign w_others     = req_in & ~w_owner_oh;
    assign w_any_other  = |w_others;
    assign w_cnt_inc    = {1'b0, r_beat_cnt} + {{CNT_W{1'b0}}, 1'b1};
    assign w_hold_limit = (w_cnt_inc >= HOLD_LIM);
    assign w_cnt_sat    = (r_beat_cnt == CNT_MAX);

    // While owned, the owner competes last, so exclude it from the scan.
    assign w_pick_req = (r_state == S_OWNED) ? w_others : req_in;

    always_comb begin
        w_pick     = r_owner;
        w_pick_hit = 1'b0;
        w_idx      = 0;
        for (int i = 1; i <= Hosts; i++) begin
            w_idx = int'(r_owner) + i;
            if (w_idx >= Hosts) begin
                w_idx = w_idx - Hosts;
            end
            if (!w_pick_hit && w_pick_req[w_idx[HOST_NUM-1:0]]) begin
                w_pick     = HOST_NUM'(w_idx);
                w_pick_hit = 1'b1;
            end
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_owner_nxt    = r_owner;
        w_beat_cnt_nxt = r_beat_cnt;
        unique case (r_state)
            S_IDLE: begin
                if (|req_in) begin
                    w_state_nxt    = S_OWNED;
                    w_owner_nxt    = w_pick;
                    w_beat_cnt_nxt = '0;
                end
            end
            S_OWNED: begin
                if (w_owner_req) begin
                    if (w_hold_limit && !w_owner_lock && w_any_other) begin
                        w_owner_nxt    = w_pick;
                        w_beat_cnt_nxt = '0;
                    end else if (!w_cnt_sat) begin
                        w_beat_cnt_nxt = w_cnt_inc[CNT_W-1:0];
                    end
                end else if (w_any_other) begin
                    w_owner_nxt    = w_pick;
                    w_beat_cnt_nxt = '0;
                end else begin
                    w_state_nxt    = S_IDLE;
                    w_beat_cnt_nxt = '0;
                end
            end
        endcase
    end

    assign w_gnt = w_owner_oh & {Hosts{(r_state == S_OWNED) && w_owner_req}};

    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            r_state      <= S_IDLE;
            r_owner      <= OWNER_RST;
            r_beat_cnt   <= '0;
            r_resp_valid <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_owner      <= w_owner_nxt;
            r_beat_cnt   <= w_beat_cnt_nxt;
            r_resp_valid <= w_gnt & ~we_in;
        end
    end

    assign gnt_out        = w_gnt;
    assign owner_out      = r_owner;
    assign busy_out       = (r_state == S_OWNED);
    assign resp_valid_out = r_resp_valid;
    assign beat_cnt_out   = r_beat_cnt;

endmodule

// File: tb/tb_bus_rr_arbiter.sv
// Scoreboard bench for bus_rr_arbiter: a cycle-level reference model pushes
// expected outputs, a negedge monitor pops and compares.
module tb_bus_rr_arbiter;

    localparam int H    = 4;
    localparam int MAXH = 8;
    localparam int OW   = 2;
    localparam int CW   = 4;

    logic          clk_in;
    logic          reset_in;
    logic [H-1:0]  req_in;
    logic [H-1:0]  we_in;
    logic [H-1:0]  lock_in;
    logic [H-1:0]  gnt_out;
    logic [OW-1:0] owner_out;
    logic          busy_out;
    logic [H-1:0]  resp_valid_out;
    logic [CW-1:0] beat_cnt_out;

    bus_rr_arbiter #(
        .Hosts   (H),
        .MaxHold (MAXH)
    ) dut (
        .clk_in         (clk_in),
        .reset_in       (reset_in),
        .req_in         (req_in),
        .we_in          (we_in),
        .lock_in        (lock_in),
        .gnt_out        (gnt_out),
        .owner_out      (owner_out),
        .busy_out       (busy_out),
        .resp_valid_out (resp_valid_out),
        .beat_cnt_out   (beat_cnt_out)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    typedef struct {
        logic [H-1:0]  gnt;
        logic [OW-1:0] owner;
        logic          busy;
        logic [H-1:0]  resp;
        logic [CW-1:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    int           m_owner;
    int           m_cnt;
    bit           m_busy;
    logic [H-1:0] m_resp;
    logic [H-1:0] last_gnt;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t",
                     name, act, exp, $time);
        end
    endtask

    function automatic int pick(input int o, input logic [H-1:0] r);
        for (int k = 1; k <= H; k++) begin
            int h;
            h = (o + k) % H;
            if (r[h]) return h;
        end
        return o;
    endfunction

    task automatic model_reset();
        m_busy  = 1'b0;
        m_owner = H - 1;
        m_cnt   = 0;
        m_resp  = '0;
    endtask

    // Advance the model across one clock edge using the inputs that edge saw.
    task automatic model_clock();
        logic [H-1:0] g;
        logic [H-1:0] others;
        g = (m_busy && req_in[m_owner]) ? (H'(1) << m_owner) : '0;
        others = req_in;
        others[m_owner] = 1'b0;
        m_resp = g & ~we_in;
        if (!m_busy) begin
            if (req_in != 0) begin
                m_busy  = 1'b1;
                m_owner = pick(m_owner, req_in);
                m_cnt   = 0;
            end
        end else if (req_in[m_owner]) begin
            if (m_cnt + 1 >= MAXH && !lock_in[m_owner] && others != 0) begin
                m_owner = pick(m_owner, others);
                m_cnt   = 0;
            end else if (m_cnt < MAXH) begin
                m_cnt++;
            end
        end else if (others != 0) begin
            m_owner = pick(m_owner, others);
            m_cnt   = 0;
        end else begin
            m_busy = 1'b0;
            m_cnt  = 0;
        end
    endtask

    task automatic push_exp();
        exp_t e;
        e.gnt   = (m_busy && req_in[m_owner]) ? (H'(1) << m_owner) : '0;
        e.owner = OW'(m_owner);
        e.busy  = m_busy;
        e.resp  = m_resp;
        e.cnt   = CW'(m_cnt);
        last_gnt = e.gnt;
        exp_q.push_back(e);
    endtask

    task automatic step(input logic [H-1:0] r, input logic [H-1:0] w,
                        input logic [H-1:0] l);
        @(posedge clk_in);
        #1;
        if (reset_in) begin
            reset_in = 1'b0;
            model_reset();
        end else begin
            model_clock();
        end
        req_in  = r;
        we_in   = w;
        lock_in = l;
        push_exp();
    endtask

    task automatic apply_reset(input logic [H-1:0] r);
        @(posedge clk_in);
        #1;
        reset_in = 1'b1;
        req_in   = r;
        model_reset();
        #1;
        chk("rst_gnt", 32'(gnt_out), 32'(0));
        chk("rst_busy", 32'(busy_out), 32'(0));
        chk("rst_resp", 32'(resp_valid_out), 32'(0));
        chk("rst_owner", 32'(owner_out), 32'(H - 1));
        chk("rst_cnt", 32'(beat_cnt_out), 32'(0));
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk_in);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("gnt", 32'(gnt_out), 32'(e.gnt));
                chk("owner", 32'(owner_out), 32'(e.owner));
                chk("busy", 32'(busy_out), 32'(e.busy));
                chk("resp", 32'(resp_valid_out), 32'(e.resp));
                chk("beat_cnt", 32'(beat_cnt_out), 32'(e.cnt));
                chk("onehot", 32'($countones(gnt_out) <= 1), 32'(1));
            end
        end
    end

    initial begin
        logic [H-1:0] rq;
        reset_in = 1'b1;
        req_in   = '1;
        we_in    = '0;
        lock_in  = '0;
        last_gnt = '0;
        model_reset();

        apply_reset(4'b1111);
        repeat (40) step(4'b1111, 4'b0000, 4'b0000);

        apply_reset(4'b0000);
        repeat (4) step(4'b0100, 4'b0000, 4'b0000);
        repeat (3) step(4'b0000, 4'b0000, 4'b0000);

        apply_reset(4'b0000);
        step(4'b0010, 4'b0000, 4'b0010);
        repeat (12) step(4'b1010, 4'b0000, 4'b0010);
        repeat (3) step(4'b1000, 4'b0000, 4'b0000);
        step(4'b0000, 4'b0000, 4'b0000);

        apply_reset(4'b0000);
        repeat (3) step(4'b1000, 4'b0000, 4'b0000);
        repeat (3) step(4'b0011, 4'b0000, 4'b0000);

        apply_reset(4'b0000);
        repeat (3) step(4'b0010, 4'b0000, 4'b0000);
        apply_reset(4'b0010);
        repeat (3) step(4'b0000, 4'b0000, 4'b0000);

        rq = '0;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 399) == 0) apply_reset(rq);
            for (int h = 0; h < H; h++) begin
                if (!rq[h]) rq[h] = ($urandom_range(0, 2) == 0);
                else if (last_gnt[h] && $urandom_range(0, 3) == 0) rq[h] = 1'b0;
            end
            step(rq, H'($urandom),
                 ($urandom_range(0, 7) == 0) ? H'($urandom) : '0);
        end

        @(negedge clk_in);
        #1;
        chk("drain", 32'(exp_q.size()), 32'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
